// File: rtl/flash_burst_csr_if.sv
// Host CSR access bundle between the PMCI host bridge and flash_burst_csr.
interface flash_burst_csr_if;
  logic [2:0]  avmm_csr_addr;
  logic        avmm_csr_write;
  logic        avmm_csr_read;
  logic [31:0] avmm_csr_wrdata;
  logic [3:0]  avmm_csr_byteen;
  logic [31:0] avmm_csr_rddata;
  logic        avmm_csr_rddvld;
  logic        avmm_csr_waitreq;

  modport master (
    output avmm_csr_addr, avmm_csr_write, avmm_csr_read, avmm_csr_wrdata, avmm_csr_byteen,
    input  avmm_csr_rddata, avmm_csr_rddvld, avmm_csr_waitreq
  );

  modport slave (
    input  avmm_csr_addr, avmm_csr_write, avmm_csr_read, avmm_csr_wrdata, avmm_csr_byteen,
    output avmm_csr_rddata, avmm_csr_rddvld, avmm_csr_waitreq
  );
endinterface

// File: rtl/flash_burst_csr.sv
// Host CSR block for the flash burst master: holds address/count/staging base and sequences one-hot modes.
// Read latency 1; waitreq forced high for one cycle after every accepted access; new mode only after a quiet drain.
module flash_burst_csr #(
  parameter int FLASH_ADDR_WIDTH = 28,
  parameter int FIFO_DEPTH_LOG2  = 9,
  parameter int QUIET_CYCLES     = 8
) (
  input  logic                        clk,
  input  logic                        reset,
  flash_burst_csr_if.slave            csr,
  output logic                        write_mode,
  output logic                        read_mode,
  output logic                        rsu_mode,
  output logic [FLASH_ADDR_WIDTH-1:0] flash_addr,
  output logic [FLASH_ADDR_WIDTH-1:0] stgng_area_baddr,
  output logic [FIFO_DEPTH_LOG2:0]    read_count,
  input  logic                        flash_busy,
  input  logic [FIFO_DEPTH_LOG2:0]    fifo_dcount
);

  localparam int          CW       = FIFO_DEPTH_LOG2 + 1;
  localparam logic [31:0] RC_MAX   = 32'(1) << FIFO_DEPTH_LOG2;
  localparam logic [3:0]  QLIM     = 4'(QUIET_CYCLES);
  localparam logic [2:0]  A_CTRL   = 3'd0;
  localparam logic [2:0]  A_STATUS = 3'd1;
  localparam logic [2:0]  A_FADDR  = 3'd2;
  localparam logic [2:0]  A_RCOUNT = 3'd3;
  localparam logic [2:0]  A_SBADDR = 3'd4;

  typedef enum logic [1:0] {IDLE = 2'd0, ACTIVE = 2'd1, DRAIN = 2'd2} state_t;

  state_t                      state_q, state_d;
  logic [2:0]                  mode_q, mode_d;
  logic [2:0]                  pend_req_q, pend_req_d;
  logic                        pend_vld_q, pend_vld_d;
  logic                        err_q, err_d;
  logic [3:0]                  quiet_q, quiet_d;
  logic                        waitreq_q, rddvld_q;
  logic [31:0]                 rddata_q, rd_mux;
  logic [FLASH_ADDR_WIDTH-1:0] faddr_q, sbaddr_q;
  logic [CW-1:0]               rcount_q;

  logic        wr_acc, rd_acc, ctrl_wr, ctrl_illegal, cfg_wr, cfg_ok;
  logic [2:0]  req;
  logic [31:0] faddr_mrg, sbaddr_mrg, rcount_mrg;

  function automatic logic [31:0] be_merge(input logic [31:0] old, input logic [31:0] wd,
                                           input logic [3:0] be);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = be[i] ? wd[8*i +: 8] : old[8*i +: 8];
    return r;
  endfunction

  assign wr_acc       = csr.avmm_csr_write & ~waitreq_q;
  assign rd_acc       = csr.avmm_csr_read & ~waitreq_q;
  assign req          = csr.avmm_csr_wrdata[2:0];
  assign ctrl_wr      = wr_acc && (csr.avmm_csr_addr == A_CTRL) && csr.avmm_csr_byteen[0];
  assign ctrl_illegal = (req & (req - 3'd1)) != 3'd0;
  assign cfg_wr       = wr_acc && (csr.avmm_csr_addr >= A_FADDR) && (csr.avmm_csr_addr <= A_SBADDR);
  assign cfg_ok       = (state_q == IDLE) && !pend_vld_q;

  assign faddr_mrg  = be_merge(32'(faddr_q), csr.avmm_csr_wrdata, csr.avmm_csr_byteen);
  assign sbaddr_mrg = be_merge(32'(sbaddr_q), csr.avmm_csr_wrdata, csr.avmm_csr_byteen);
  assign rcount_mrg = be_merge(32'(rcount_q), csr.avmm_csr_wrdata, csr.avmm_csr_byteen);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      mode_q     <= '0;
      pend_req_q <= '0;
      pend_vld_q <= 1'b0;
      err_q      <= 1'b0;
      quiet_q    <= '0;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      pend_req_q <= pend_req_d;
      pend_vld_q <= pend_vld_d;
      err_q      <= err_d;
      quiet_q    <= quiet_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    pend_req_d = pend_req_q;
    pend_vld_d = pend_vld_q;
    err_d      = err_q;
    quiet_d    = '0;

    if (ctrl_wr && ctrl_illegal) err_d = 1'b1;
    if (cfg_wr && !cfg_ok)       err_d = 1'b1;
    if (wr_acc && (csr.avmm_csr_addr == A_STATUS) && csr.avmm_csr_byteen[0] &&
        csr.avmm_csr_wrdata[2])
      err_d = 1'b0;

    case (state_q)
      IDLE: begin
        mode_d = '0;
        // A fresh request is parked for one cycle; otherwise launch what is pending.
        if (ctrl_wr && !ctrl_illegal) begin
          pend_req_d = req;
          pend_vld_d = (req != 3'd0);
        end else if (pend_vld_q) begin
          mode_d     = pend_req_q;
          pend_req_d = '0;
          pend_vld_d = 1'b0;
          state_d    = ACTIVE;
        end
      end
      ACTIVE: begin
        if (ctrl_wr && !ctrl_illegal && (req != mode_q)) begin
          mode_d     = '0;
          pend_req_d = req;
          pend_vld_d = (req != 3'd0);
          state_d    = DRAIN;
        end
      end
      DRAIN: begin
        mode_d = '0;
        if (ctrl_wr && !ctrl_illegal) begin
          pend_req_d = req;
          pend_vld_d = (req != 3'd0);
        end
        if (!flash_busy) quiet_d = (quiet_q == QLIM) ? quiet_q : quiet_q + 4'd1;
        if (quiet_q == QLIM) state_d = IDLE;
      end
      default: begin
        mode_d  = '0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      faddr_q  <= '0;
      sbaddr_q <= '0;
      rcount_q <= '0;
    end else if (cfg_wr && cfg_ok) begin
      case (csr.avmm_csr_addr)
        A_FADDR:  faddr_q  <= {faddr_mrg[FLASH_ADDR_WIDTH-1:2], 2'b00};
        A_SBADDR: sbaddr_q <= {sbaddr_mrg[FLASH_ADDR_WIDTH-1:2], 2'b00};
        A_RCOUNT: rcount_q <= (rcount_mrg > RC_MAX) ? RC_MAX[CW-1:0] : rcount_mrg[CW-1:0];
        default: ;
      endcase
    end
  end

  always_comb begin
    rd_mux = '0;
    case (csr.avmm_csr_addr)
      A_CTRL:   rd_mux = {22'd0, state_q, 1'b0, pend_req_q, 1'b0, mode_q};
      A_STATUS: begin
        rd_mux[16 +: CW] = fifo_dcount;
        rd_mux[2:0]      = {err_q, pend_vld_q, flash_busy};
      end
      A_FADDR:  rd_mux = 32'(faddr_q);
      A_RCOUNT: rd_mux = 32'(rcount_q);
      A_SBADDR: rd_mux = 32'(sbaddr_q);
      default:  rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      waitreq_q <= 1'b1;
      rddvld_q  <= 1'b0;
      rddata_q  <= '0;
    end else begin
      waitreq_q <= wr_acc | rd_acc;
      rddvld_q  <= rd_acc;
      rddata_q  <= rd_acc ? rd_mux : 32'd0;
    end
  end

  assign csr.avmm_csr_waitreq = waitreq_q;
  assign csr.avmm_csr_rddvld  = rddvld_q;
  assign csr.avmm_csr_rddata  = rddata_q;
  assign write_mode           = mode_q[0];
  assign read_mode            = mode_q[1];
  assign rsu_mode             = mode_q[2];
  assign flash_addr           = faddr_q;
  assign stgng_area_baddr     = sbaddr_q;
  assign read_count           = rcount_q;

endmodule

// File: tb/tb_flash_burst_csr.sv
// Directed bench for flash_burst_csr: register access, mode sequencing, drain timing, locking and reset.
module tb_flash_burst_csr;
  localparam int FAW = 28;
  localparam int L   = 9;
  localparam int Q   = 8;

  logic           clk = 1'b0;
  logic           reset;
  logic           write_mode, read_mode, rsu_mode;
  logic [FAW-1:0] flash_addr, stgng_area_baddr;
  logic [L:0]     read_count;
  logic           flash_busy;
  logic [L:0]     fifo_dcount;

  int checks   = 0;
  int failures = 0;

  flash_burst_csr_if bus ();

  flash_burst_csr #(.FLASH_ADDR_WIDTH(FAW), .FIFO_DEPTH_LOG2(L), .QUIET_CYCLES(Q)) dut (
    .clk              (clk),
    .reset            (reset),
    .csr              (bus),
    .write_mode       (write_mode),
    .read_mode        (read_mode),
    .rsu_mode         (rsu_mode),
    .flash_addr       (flash_addr),
    .stgng_area_baddr (stgng_area_baddr),
    .read_count       (read_count),
    .flash_busy       (flash_busy),
    .fifo_dcount      (fifo_dcount)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic wait_rdy();
    int n = 0;
    while (bus.avmm_csr_waitreq && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (bus.avmm_csr_waitreq) chk("waitreq_timeout", 32'(bus.avmm_csr_waitreq), 32'd0);
  endtask

  // Returns at the falling edge of the cycle after acceptance.
  task automatic csr_wr(input logic [2:0] a, input logic [31:0] d, input logic [3:0] be);
    wait_rdy();
    bus.avmm_csr_addr   = a;
    bus.avmm_csr_wrdata = d;
    bus.avmm_csr_byteen = be;
    bus.avmm_csr_write  = 1'b1;
    @(negedge clk);
    bus.avmm_csr_write  = 1'b0;
  endtask

  task automatic csr_rd(input logic [2:0] a, output logic [31:0] d);
    wait_rdy();
    bus.avmm_csr_addr = a;
    bus.avmm_csr_read = 1'b1;
    @(negedge clk);
    bus.avmm_csr_read = 1'b0;
    chk("rddvld_pulse", 32'(bus.avmm_csr_rddvld), 32'd1);
    d = bus.avmm_csr_rddata;
  endtask

  function automatic logic [31:0] modes();
    return 32'({rsu_mode, read_mode, write_mode});
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] d;
    int n;

    reset                = 1'b1;
    bus.avmm_csr_addr    = '0;
    bus.avmm_csr_write   = 1'b0;
    bus.avmm_csr_read    = 1'b0;
    bus.avmm_csr_wrdata  = '0;
    bus.avmm_csr_byteen  = '0;
    flash_busy           = 1'b0;
    fifo_dcount          = '0;
    repeat (2) @(negedge clk);

    chk("rst_waitreq", 32'(bus.avmm_csr_waitreq), 32'd1);
    chk("rst_modes", modes(), 32'd0);
    chk("rst_rddvld", 32'(bus.avmm_csr_rddvld), 32'd0);
    chk("rst_rddata", bus.avmm_csr_rddata, 32'd0);
    chk("rst_faddr", 32'(flash_addr), 32'd0);
    chk("rst_rcount", 32'(read_count), 32'd0);

    reset = 1'b0;
    #1 chk("waitreq_hold", 32'(bus.avmm_csr_waitreq), 32'd1);
    @(negedge clk);
    chk("waitreq_drop", 32'(bus.avmm_csr_waitreq), 32'd0);

    csr_rd(3'd0, d);
    chk("ctrl_idle", d, 32'h0);
    @(negedge clk);
    chk("rddvld_one_cycle", 32'(bus.avmm_csr_rddvld), 32'd0);

    // Mode entry: mode appears two cycles after acceptance.
    csr_wr(3'd0, 32'h1, 4'h1);
    chk("entry_lat1", modes(), 32'd0);
    @(negedge clk);
    chk("entry_lat2", modes(), 32'b001);
    csr_rd(3'd0, d);
    chk("ctrl_active_wr", d, 32'h101);

    // Config locked while active.
    csr_wr(3'd2, 32'h0123_4567, 4'hF);
    csr_rd(3'd2, d);
    chk("lock_faddr", d, 32'h0);
    csr_rd(3'd1, d);
    chk("lock_err", d, 32'h4);
    csr_wr(3'd1, 32'h4, 4'h1);
    csr_rd(3'd1, d);
    chk("err_clear", d, 32'h0);

    // Illegal multi-bit request.
    csr_wr(3'd0, 32'h3, 4'h1);
    csr_rd(3'd0, d);
    chk("illegal_ctrl", d, 32'h101);
    chk("illegal_modes", modes(), 32'b001);
    csr_rd(3'd1, d);
    chk("illegal_err", d, 32'h4);
    csr_wr(3'd1, 32'h4, 4'h1);

    // Switch write -> read through a drain held off by busy.
    flash_busy = 1'b1;
    csr_wr(3'd0, 32'h2, 4'h1);
    chk("switch_drop", modes(), 32'd0);
    csr_rd(3'd0, d);
    chk("ctrl_drain", d, 32'h220);
    repeat (20) @(negedge clk);
    flash_busy = 1'b0;
    n = 0;
    while (!read_mode && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("drain_gap", 32'(n), 32'(Q + 2));
    chk("read_mode_on", modes(), 32'b010);

    // Switch read -> write with a busy blip at quiet count 5.
    flash_busy = 1'b1;
    csr_wr(3'd0, 32'h1, 4'h1);
    repeat (3) @(negedge clk);
    flash_busy = 1'b0;
    repeat (5) @(negedge clk);
    flash_busy = 1'b1;
    @(negedge clk);
    flash_busy = 1'b0;
    n = 0;
    while (!write_mode && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("blip_restart", 32'(n), 32'(Q + 2));
    chk("write_mode_on", modes(), 32'b001);

    // Back to idle.
    csr_wr(3'd0, 32'h0, 4'h1);
    chk("stop_drop", modes(), 32'd0);
    repeat (12) @(negedge clk);
    csr_rd(3'd0, d);
    chk("ctrl_back_idle", d, 32'h0);

    // Config writes in idle.
    csr_wr(3'd2, 32'h0123_4567, 4'hF);
    chk("faddr_out", 32'(flash_addr), 32'h0123_4564);
    csr_rd(3'd2, d);
    chk("faddr_rd", d, 32'h0123_4564);
    csr_wr(3'd2, 32'hFFFF_FFFF, 4'h2);
    csr_rd(3'd2, d);
    chk("faddr_byteen", d, 32'h0123_FF64);
    csr_wr(3'd3, 32'h3FF, 4'hF);
    chk("rcount_clamp", 32'(read_count), 32'd512);
    csr_rd(3'd3, d);
    chk("rcount_rd", d, 32'h200);
    csr_wr(3'd3, 32'h1FF, 4'hF);
    chk("rcount_noclamp", 32'(read_count), 32'h1FF);
    csr_wr(3'd4, 32'h0ABC_DEFF, 4'hF);
    chk("sbaddr_out", 32'(stgng_area_baddr), 32'h0ABC_DEFC);
    csr_wr(3'd5, 32'hFFFF_FFFF, 4'hF);
    csr_rd(3'd5, d);
    chk("unmapped_rd", d, 32'h0);

    fifo_dcount = 10'h1A0;
    flash_busy  = 1'b1;
    csr_rd(3'd1, d);
    chk("status_dcount", d, 32'h01A0_0001);

    // Reset in the middle of an active write mode.
    flash_busy  = 1'b0;
    fifo_dcount = '0;
    csr_wr(3'd0, 32'h1, 4'h1);
    @(negedge clk);
    chk("pre_reset_mode", modes(), 32'b001);
    reset = 1'b1;
    #1;
    chk("async_rst_modes", modes(), 32'd0);
    chk("async_rst_waitreq", 32'(bus.avmm_csr_waitreq), 32'd1);
    chk("async_rst_faddr", 32'(flash_addr), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst_waitreq", 32'(bus.avmm_csr_waitreq), 32'd0);
    csr_rd(3'd0, d);
    chk("post_rst_ctrl", d, 32'h0);
    csr_rd(3'd1, d);
    chk("post_rst_status", d, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/flash_burst_csr.md
# flash_burst_csr

Host-facing control/status register block that sits directly upstream of the flash burst master in the PMCI flash path. It decodes host CSR accesses, holds the flash address, read count and staging-area base address, and sequences the one-hot write/read/RSU mode outputs. Mode changes are ordered so that a new mode is never raised until the burst master has drained and gone quiet.

## Interface
Parameters:
- FLASH_ADDR_WIDTH, 28, width of flash byte address outputs
- FIFO_DEPTH_LOG2, 9, log2 of burst master FIFO depth
- QUIET_CYCLES, 8, consecutive cycles of flash_busy=0 required to leave DRAIN (2..15)

Ports:
- clk  in  1  single clock
- reset  in  1  asynchronous, active-high reset
- avmm_csr_addr  in  3  word address (reg index 0..4)
- avmm_csr_write  in  1  write request
- avmm_csr_read  in  1  read request
- avmm_csr_wrdata  in  32  write data
- avmm_csr_byteen  in  4  byte enables
- avmm_csr_rddata  out  32  read data
- avmm_csr_rddvld  out  1  read data valid
- avmm_csr_waitreq  out  1  wait request
- write_mode  out  1  flash write mode to burst master
- read_mode  out  1  flash read mode to burst master
- rsu_mode  out  1  RSU staging write mode to burst master
- flash_addr  out  FLASH_ADDR_WIDTH  flash start address, [1:0] always 0
- stgng_area_baddr  out  FLASH_ADDR_WIDTH  staging base address, [1:0] always 0
- read_count  out  FIFO_DEPTH_LOG2+1  words to read in read mode
- flash_busy  in  1  burst master busy
- fifo_dcount  in  FIFO_DEPTH_LOG2+1  free FIFO words reported by burst master

## Operation
- Registers (index): 0 CTRL, 1 STATUS, 2 FLASH_ADDR, 3 READ_COUNT, 4 STGNG_BADDR; other indices read 0, writes ignored.
- CTRL write (needs byteen[0]): wrdata[2:0] = {rsu, read, write} request. More than one bit set: ignored, STATUS.err set. CTRL read: [2:0] driven modes, [6:4] pending request, [9:8] FSM state encoding (IDLE 0, ACTIVE 1, DRAIN 2).
- STATUS read: [0] flash_busy, [1] pending_valid, [2] err (sticky), [16+FIFO_DEPTH_LOG2:16] fifo_dcount. Writing 1 to bit 2 (byteen[0]) clears err.
- Config registers (2,3,4): writable only in IDLE with no pending request; otherwise ignored and err set. Byte enables honored per byte. Address bits [1:0] stored as 0. READ_COUNT values > 2**FIFO_DEPTH_LOG2 clamp to 2**FIFO_DEPTH_LOG2.
- FSM:
  - IDLE: all modes 0. If pending_valid, drive pending mode next cycle, clear pending, go ACTIVE. A nonzero CTRL write in IDLE is latched as pending and taken on the following cycle.
  - ACTIVE: exactly one mode driven. CTRL write equal to current mode is a no-op. CTRL write 0 drops all modes and goes to DRAIN. A different nonzero legal value drops modes, latches it as pending, and goes to DRAIN.
  - DRAIN: modes 0. quiet_cnt counts consecutive cycles of flash_busy=0 and is cleared on any flash_busy=1. Go IDLE when quiet_cnt reaches QUIET_CYCLES. A legal CTRL write here overwrites pending (last write wins); a write of 0 clears pending.
- Simultaneous events: a CTRL write and a DRAIN exit in the same cycle take the write into pending before IDLE evaluates it.
- Reset mid-operation: all modes drop immediately (async), pending is cleared, and the FSM returns to IDLE.

## Timing
- Reset values: all mode outputs 0; flash_addr, stgng_area_baddr, read_count 0; avmm_csr_rddata 0; rddvld 0; waitreq 1; err 0; FSM IDLE.
- waitreq drops 1 cycle after reset deassertion. Every accepted access (read or write with waitreq=0) forces waitreq=1 for exactly the next cycle, so accepted accesses are at least 2 cycles apart.
- Read latency is fixed at 1: rddvld=1 with rddata in the cycle after acceptance, for one cycle.
- A register write takes effect on the cycle after acceptance.
- Mode outputs are registered. ACTIVE→DRAIN drops the mode 1 cycle after the CTRL write is accepted.
- Minimum mode-off gap on a switch: QUIET_CYCLES + 2 cycles.

## Test plan
- Reset: assert reset mid-ACTIVE with write_mode=1 -> all modes 0 immediately, waitreq=1; after release, waitreq=0 one cycle later and CTRL reads 0x0.
- Mode entry: write CTRL=0x1 in IDLE -> write_mode=1 two cycles after acceptance; CTRL reads 0x101.
- Switch with drain: ACTIVE write, write CTRL=0x2, hold flash_busy=1 for 20 cycles then 0 -> read_mode rises exactly QUIET_CYCLES+2 cycles after busy falls. A single-cycle busy blip at quiet_cnt=5 restarts the count.
- Illegal request: write CTRL=0x3 -> modes unchanged, STATUS[2]=1; write STATUS=0x4 -> STATUS[2]=0.
- Lock: in ACTIVE, write FLASH_ADDR=0x0123_4567 -> readback unchanged, err=1. In IDLE, write 0x0123_4567 with byteen=0xF -> reads 0x0123_4564.
- Clamp and STATUS: write READ_COUNT=0x3FF -> read_count=512. Drive fifo_dcount=0x1A0, flash_busy=1 -> STATUS reads 0x01A0_0001.
